// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between the pipeline write-back stage and a buffered
// auxiliary result queue, with WAW squashing, hazard flags and a starvation-forced grant.
module regfile_wport_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_waddr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              pend1,
  output logic              pend2,
  output logic              stall_req,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  logic [FIFO_DEPTH-1:0] live_q;
  logic [ADDR_W-1:0]     addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [StW-1:0]        starve_q;

  logic wb_real, head_present, head_live, enq, deq, squash, stall_int, we_int;
  logic [ADDR_W-1:0] waddr_int;
  logic [DATA_W-1:0] wdata_int;
  logic pend1_int, pend2_int;

  assign wb_real      = wb_we && (wb_waddr != '0);
  assign head_present = (count_q != '0);
  assign head_live    = live_q[rd_ptr_q];
  assign aux_ready    = !rst && (count_q != CntW'(FIFO_DEPTH));
  // Address-0 results are accepted but dropped.
  assign enq          = aux_valid && aux_ready && (aux_waddr != '0);
  assign stall_int    = wb_real && head_present && head_live &&
                        (starve_q == StW'(STARVE_MAX));

  always_comb begin
    we_int    = 1'b0;
    waddr_int = '0;
    wdata_int = '0;
    deq       = 1'b0;
    squash    = 1'b0;
    if (stall_int) begin
      we_int    = 1'b1;
      waddr_int = addr_q[rd_ptr_q];
      wdata_int = data_q[rd_ptr_q];
      deq       = 1'b1;
    end else if (wb_real) begin
      we_int    = 1'b1;
      waddr_int = wb_waddr;
      wdata_int = wb_wdata;
      squash    = 1'b1;
      // Squashed heads need no port slot, so they drain under pipeline traffic.
      deq       = head_present && !head_live;
    end else if (head_present) begin
      deq       = 1'b1;
      we_int    = head_live;
      waddr_int = addr_q[rd_ptr_q];
      wdata_int = data_q[rd_ptr_q];
    end
  end

  // Squashed and dequeued entries have live=0, so live alone marks a pending write.
  always_comb begin
    pend1_int = 1'b0;
    pend2_int = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (live_q[i] && (addr_q[i] == raddr1)) pend1_int = 1'b1;
      if (live_q[i] && (addr_q[i] == raddr2)) pend2_int = 1'b1;
    end
  end

  assign pend1     = !rst && pend1_int && (raddr1 != '0);
  assign pend2     = !rst && pend2_int && (raddr2 != '0);
  assign stall_req = !rst && stall_int;
  assign we        = !rst && we_int;
  assign waddr     = rst ? '0 : waddr_int;
  assign wdata     = rst ? '0 : wdata_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (squash && live_q[i] && (addr_q[i] == wb_waddr)) live_q[i] <= 1'b0;
      end
      if (deq) begin
        live_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + PtrW'(1);
      end
      if (enq) begin
        live_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (!head_present || deq) begin
        starve_q <= '0;
      end else if (head_live && wb_real) begin
        starve_q <= starve_q + StW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= aux_waddr;
      data_q[wr_ptr_q] <= aux_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Random and directed stimulus for regfile_wport_arbiter, checked every cycle against a
// queue-based reference model plus literal expectations for the key scenarios.
module tb_regfile_wport_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst, wb_we, aux_valid, aux_ready, pend1, pend2, stall_req, we;
  logic [4:0]  wb_waddr, aux_waddr, raddr1, raddr2, waddr;
  logic [31:0] wb_wdata, aux_wdata, wdata;

  regfile_wport_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_waddr(aux_waddr),
    .aux_wdata(aux_wdata), .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1),
    .pend2(pend2), .stall_req(stall_req), .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        live;
    bit [4:0]  addr;
    bit [31:0] data;
  } ent_t;

  ent_t      q[$];
  int        starve = 0;
  int        n_checks = 0;
  int        n_fail = 0;
  bit        mvalid = 0;
  bit        m_real, m_hl, m_deq, m_squash;
  bit        e_we, e_ready, e_stall, e_p1, e_p2;
  bit [4:0]  e_waddr;
  bit [31:0] e_wdata;
  bit [31:0] rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the queue model for the inputs currently applied.
  task automatic eval();
    e_we = 0; e_waddr = 0; e_wdata = 0; e_stall = 0; e_p1 = 0; e_p2 = 0; e_ready = 0;
    m_deq = 0; m_squash = 0;
    m_real = wb_we && (wb_waddr != 0);
    m_hl   = (q.size() > 0) && q[0].live;
    if (!rst) begin
      e_ready = q.size() < DEPTH;
      e_stall = m_real && m_hl && (starve == SMAX);
      if (e_stall) begin
        e_we = 1; e_waddr = q[0].addr; e_wdata = q[0].data; m_deq = 1;
      end else if (m_real) begin
        e_we = 1; e_waddr = wb_waddr; e_wdata = wb_wdata; m_squash = 1;
        m_deq = (q.size() > 0) && !q[0].live;
      end else if (q.size() > 0) begin
        m_deq = 1; e_we = q[0].live; e_waddr = q[0].addr; e_wdata = q[0].data;
      end
      foreach (q[i]) begin
        if (q[i].live && q[i].addr == raddr1 && raddr1 != 0) e_p1 = 1;
        if (q[i].live && q[i].addr == raddr2 && raddr2 != 0) e_p2 = 1;
      end
    end
    chk("aux_ready", aux_ready, e_ready);
    chk("we", we, e_we);
    chk("stall_req", stall_req, e_stall);
    chk("pend1", pend1, e_p1);
    chk("pend2", pend2, e_p2);
    if (e_we || rst) begin
      chk("waddr", waddr, e_waddr);
      chk("wdata", wdata, e_wdata);
    end
    if (we === 1'b1) rf[waddr] = wdata;
    mvalid = 1;
  endtask

  always @(posedge clk) begin
    if (mvalid) begin
      if (rst) begin
        q.delete();
        starve = 0;
      end else begin
        if (q.size() == 0 || m_deq) starve = 0;
        else if (m_hl && m_real) starve = starve + 1;
        if (m_squash) foreach (q[i]) if (q[i].live && q[i].addr == wb_waddr) q[i].live = 0;
        if (m_deq) void'(q.pop_front());
        if (e_ready && aux_valid && aux_waddr != 0)
          q.push_back('{live: 1'b1, addr: aux_waddr, data: aux_wdata});
      end
    end
  end

  task automatic cyc(input bit r, input bit wbe, input bit [4:0] wba, input bit [31:0] wbd,
                     input bit av, input bit [4:0] aa, input bit [31:0] ad,
                     input bit [4:0] r1, input bit [4:0] r2);
    @(negedge clk);
    rst = r; wb_we = wbe; wb_waddr = wba; wb_wdata = wbd;
    aux_valid = av; aux_waddr = aa; aux_wdata = ad; raddr1 = r1; raddr2 = r2;
    #1;
    eval();
  endtask

  initial begin
    rst = 1; wb_we = 0; wb_waddr = 0; wb_wdata = 0; aux_valid = 0; aux_waddr = 0;
    aux_wdata = 0; raddr1 = 0; raddr2 = 0;
    foreach (rf[i]) rf[i] = 0;
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_ready", aux_ready, 1'b1);
    chk("reset_we", we, 1'b0);

    // Reset mid-queue discards both entries.
    cyc(0, 1, 10, 32'h100, 1, 12, 32'hAA, 12, 13);
    cyc(0, 1, 10, 32'h101, 1, 13, 32'hBB, 12, 13);
    chk("rq_pend1", pend1, 1'b1);
    cyc(1, 1, 10, 32'h102, 1, 14, 32'hCC, 12, 13);
    chk("rq_rst_we", we, 1'b0);
    chk("rq_rst_ready", aux_ready, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 12, 13);
    chk("rq_ready", aux_ready, 1'b1);
    chk("rq_we", we, 1'b0);
    chk("rq_pend1_clr", pend1, 1'b0);
    chk("rq_pend2_clr", pend2, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 12, 13);
    chk("rq_no_late_write", we, 1'b0);

    // Idle pipeline: one-cycle aux latency.
    cyc(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    chk("lat_pend_in", pend1, 1'b0);
    chk("lat_we0", we, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("lat_we", we, 1'b1);
    chk("lat_waddr", waddr, 32'd5);
    chk("lat_wdata", wdata, 32'hDEADBEEF);
    chk("lat_pend", pend1, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("lat_pend_drop", pend1, 1'b0);

    // Starvation: forced grant after four blocked cycles.
    cyc(0, 1, 10, 32'h1000, 1, 3, 32'h33, 3, 4);
    cyc(0, 1, 10, 32'h1001, 1, 4, 32'h44, 3, 4);
    chk("st_wb_waddr", waddr, 32'd10);
    cyc(0, 1, 10, 32'h1002, 1, 6, 32'h66, 3, 4);
    chk("st_full_ready", aux_ready, 1'b0);
    cyc(0, 1, 10, 32'h1003, 0, 0, 0, 3, 4);
    cyc(0, 1, 10, 32'h1004, 0, 0, 0, 3, 4);
    chk("st_no_stall_yet", stall_req, 1'b0);
    cyc(0, 1, 10, 32'h1005, 0, 0, 0, 3, 4);
    chk("st_stall", stall_req, 1'b1);
    chk("st_head_waddr", waddr, 32'd3);
    chk("st_head_wdata", wdata, 32'h33);
    cyc(0, 1, 10, 32'h1005, 0, 0, 0, 3, 4);
    chk("st_repr_stall", stall_req, 1'b0);
    chk("st_repr_wdata", wdata, 32'h1005);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("st_r4_waddr", waddr, 32'd4);
    chk("st_r4_wdata", wdata, 32'h44);

    // WAW squash of a queued r7.
    cyc(0, 1, 8, 32'h88, 1, 7, 32'h1, 7, 0);
    cyc(0, 1, 7, 32'h2, 0, 0, 0, 7, 0);
    chk("sq_pend", pend1, 1'b1);
    chk("sq_wdata", wdata, 32'h2);
    cyc(0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("sq_pend_drop", pend1, 1'b0);
    chk("sq_pop_we", we, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("sq_r7_final", rf[7], 32'h2);

    // Address-0 aux result is accepted and dropped.
    cyc(0, 0, 0, 0, 1, 0, 32'h55, 0, 0);
    chk("a0_ready", aux_ready, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("a0_no_write", we, 1'b0);

    // wb_we to r0 is no request: head r9 takes the port.
    cyc(0, 1, 11, 32'h11, 1, 9, 32'h99, 9, 0);
    cyc(0, 1, 0, 32'hFF, 0, 0, 0, 9, 0);
    chk("r0_waddr", waddr, 32'd9);
    chk("r0_wdata", wdata, 32'h99);
    chk("r0_stall", stall_req, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      bit busy;
      busy = (n / 300) % 2 == 1;
      cyc($urandom_range(0, 99) == 0,
          busy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
